// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RISC-V core.
// In: clk, rst_n, opcode, mem_ready. Out: datapath selects/strobes, retire/illegal, retired_cnt, state.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       aluOp,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_WB  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            c;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    c        = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.src_b    = 2'b01;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        c.src_b  = 2'b10;
        opcode_d = opcode;
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_d = S_MEM_ADDR;
          (opcode == OP_RTYPE):  state_d = S_EXEC_R;
          (opcode == OP_BRANCH): state_d = S_BRANCH;
          default: begin
            c.illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.src_a = 1'b1;
        c.src_b = 2'b10;
        unique case (1'b1)
          (opcode_q == OP_LOAD):  state_d = S_MEM_RD;
          (opcode_q == OP_STORE): state_d = S_MEM_WR;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready) begin
          c.retire = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        c.src_a  = 1'b1;
        c.alu_op = 2'b10;
        state_d  = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        c.src_a         = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
        c.retire        = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = c.retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign {aluOp, alu_src_a, alu_src_b, iord, mem_read, mem_write,
          ir_write, pc_write, pc_write_cond, pc_src, reg_write,
          mem_to_reg, retire, illegal} = rst_n ? c : '0;

  assign retired_cnt = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, corner sequences and random run
// against an instruction-level model, on a 32-bit and a 4-bit counter copy.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        mem_ready = 1'b0;

  logic [1:0]  aluOp, aluOp4;
  logic        alu_src_a, alu_src_a4;
  logic [1:0]  alu_src_b, alu_src_b4;
  logic        iord, mem_read, mem_write, ir_write, pc_write;
  logic        pc_write_cond, pc_src, reg_write, mem_to_reg;
  logic        retire, illegal;
  logic        iord4, mem_read4, mem_write4, ir_write4, pc_write4;
  logic        pc_write_cond4, pc_src4, reg_write4, mem_to_reg4;
  logic        retire4, illegal4;
  logic [31:0] retired_cnt;
  logic [3:0]  retired_cnt4;
  logic [3:0]  state, state4;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m = 0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] BR = 7'b1100011;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .aluOp(aluOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .retire(retire), .illegal(illegal),
    .retired_cnt(retired_cnt), .state(state)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .aluOp(aluOp4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .iord(iord4), .mem_read(mem_read4), .mem_write(mem_write4),
    .ir_write(ir_write4), .pc_write(pc_write4),
    .pc_write_cond(pc_write_cond4), .pc_src(pc_src4),
    .reg_write(reg_write4), .mem_to_reg(mem_to_reg4),
    .retire(retire4), .illegal(illegal4),
    .retired_cnt(retired_cnt4), .state(state4)
  );

  // {aluOp, src_a, src_b, iord, mrd, mwr, irw, pcw, pwc, psrc, rw, m2r, ret, ill}
  logic [15:0] ctl, ctl4;
  assign ctl = {aluOp, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                ir_write, pc_write, pc_write_cond, pc_src, reg_write,
                mem_to_reg, retire, illegal};
  assign ctl4 = {aluOp4, alu_src_a4, alu_src_b4, iord4, mem_read4,
                 mem_write4, ir_write4, pc_write4, pc_write_cond4, pc_src4,
                 reg_write4, mem_to_reg4, retire4, illegal4};

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    int          cnt;
  } vec_t;

  function automatic logic [15:0] exp_ctrl(input int ph, input bit rdy,
                                           input bit bad);
    logic [1:0] op, sb;
    bit sa, io, mr, mw, irw, pcw, pwc, ps, rw, m2r, ret, ill;
    op = 2'b00; sb = 2'b00;
    {sa, io, mr, mw, irw, pcw, pwc, ps, rw, m2r, ret, ill} = '0;
    case (ph)
      0: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin sb = 2'b10; ill = bad; end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; ret = 1; end
      5: begin mw = 1; io = 1; ret = rdy; end
      6: begin sa = 1; op = 2'b10; end
      7: begin rw = 1; ret = 1; end
      8: begin sa = 1; op = 2'b01; pwc = 1; ps = 1; ret = 1; end
      default: ;
    endcase
    return {op, sa, sb, io, mr, mw, irw, pcw, pwc, ps, rw, m2r, ret, ill};
  endfunction

  task automatic check(input string nm, input logic [3:0] es,
                       input logic [15:0] ec, input int ecnt);
    logic [31:0] c32;
    logic [3:0]  c4;
    c32 = 32'(ecnt);
    c4  = c32[3:0];
    n_cmp++;
    if (state !== es) begin
      n_bad++;
      $display("FAIL %s state got %0d want %0d", nm, state, es);
    end
    n_cmp++;
    if (ctl !== ec) begin
      n_bad++;
      $display("FAIL %s ctrl got %h want %h", nm, ctl, ec);
    end
    n_cmp++;
    if (retired_cnt !== c32) begin
      n_bad++;
      $display("FAIL %s cnt got %0d want %0d", nm, retired_cnt, c32);
    end
    n_cmp++;
    if ({state4, ctl4} !== {es, ec}) begin
      n_bad++;
      $display("FAIL %s w4 st/ctrl got %0d/%h want %0d/%h",
               nm, state4, ctl4, es, ec);
    end
    n_cmp++;
    if (retired_cnt4 !== c4) begin
      n_bad++;
      $display("FAIL %s cnt4 got %0d want %0d", nm, retired_cnt4, c4);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] op,
                      input logic rdy, input logic [3:0] es,
                      input logic [15:0] ec, input int ecnt);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    #1;
    check(nm, es, ec, ecnt);
  endtask

  // Instruction-level model: phase list per instruction class,
  // wait phases repeat until mem_ready is seen high.
  task automatic run_instr(input int kind, input bit rnd);
    int ph[$];
    logic [6:0] op;
    logic [6:0] d;
    logic [15:0] ec;
    bit rdy, done;
    int waits;
    case (kind)
      0: begin op = LD; ph = '{0, 1, 2, 3, 4}; end
      1: begin op = ST; ph = '{0, 1, 2, 5}; end
      2: begin op = RT; ph = '{0, 1, 6, 7}; end
      3: begin op = BR; ph = '{0, 1, 8}; end
      default: begin
        do op = 7'($urandom);
        while (op == LD || op == ST || op == RT || op == BR);
        ph = '{0, 1};
      end
    endcase
    foreach (ph[k]) begin
      waits = 0;
      do begin
        rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (waits >= 6) rdy = 1'b1;
        d = (ph[k] == 1) ? op : (rnd ? 7'($urandom) : 7'h00);
        ec = exp_ctrl(ph[k], rdy, kind == 4);
        step("model", d, rdy, 4'(ph[k]), ec, cnt_m);
        if (ec[1]) cnt_m++;
        done = !(ph[k] == 0 || ph[k] == 3 || ph[k] == 5) || rdy;
        waits++;
      end while (!done);
    end
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{7'h00, 1'b1, 4'd0, 16'h0AC0, 0},
      '{RT,    1'b1, 4'd1, 16'h1000, 0},
      '{7'h00, 1'b1, 4'd6, 16'hA000, 0},
      '{7'h00, 1'b1, 4'd7, 16'h000A, 0},
      '{7'h00, 1'b1, 4'd0, 16'h0AC0, 1},
      '{LD,    1'b1, 4'd1, 16'h1000, 1},
      '{7'h00, 1'b1, 4'd2, 16'h3000, 1},
      '{7'h00, 1'b0, 4'd3, 16'h0600, 1},
      '{7'h00, 1'b0, 4'd3, 16'h0600, 1},
      '{7'h00, 1'b0, 4'd3, 16'h0600, 1},
      '{7'h00, 1'b1, 4'd3, 16'h0600, 1},
      '{7'h00, 1'b1, 4'd4, 16'h000E, 1},
      '{7'h00, 1'b1, 4'd0, 16'h0AC0, 2},
      '{ST,    1'b1, 4'd1, 16'h1000, 2},
      '{7'h00, 1'b1, 4'd2, 16'h3000, 2},
      '{7'h00, 1'b1, 4'd5, 16'h0502, 2},
      '{7'h00, 1'b1, 4'd0, 16'h0AC0, 3},
      '{BR,    1'b1, 4'd1, 16'h1000, 3},
      '{7'h00, 1'b1, 4'd8, 16'h6032, 3},
      '{7'h00, 1'b0, 4'd0, 16'h0A00, 4},
      '{7'h00, 1'b0, 4'd0, 16'h0A00, 4},
      '{7'h00, 1'b1, 4'd0, 16'h0AC0, 4},
      '{7'h7F, 1'b1, 4'd1, 16'h1001, 4},
      '{7'h00, 1'b0, 4'd0, 16'h0A00, 4}
    };

    #1;
    check("reset", 4'd0, 16'h0000, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].rdy,
           tbl[i].st, tbl[i].ctl, tbl[i].cnt);
    cnt_m = 4;

    // Reset asserted in the middle of a load's memory wait.
    step("rd_f",  7'h00, 1'b1, 4'd0, 16'h0AC0, 4);
    step("rd_d",  LD,    1'b1, 4'd1, 16'h1000, 4);
    step("rd_a",  7'h00, 1'b1, 4'd2, 16'h3000, 4);
    step("rd_w",  7'h00, 1'b0, 4'd3, 16'h0600, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", 4'd0, 16'h0000, 0);
    cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_f0", 7'h00, 1'b0, 4'd0, 16'h0A00, 0);
    run_instr(2, 1'b0);
    step("post_f1", 7'h00, 1'b0, 4'd0, 16'h0A00, 1);

    // Counter wrap on the 4-bit copy.
    @(negedge clk);
    rst_n = 1'b0;
    cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) run_instr(2, 1'b0);
    step("wrap", 7'h00, 1'b0, 4'd0, 16'h0A00, 17);

    for (int i = 0; i < 300; i++)
      run_instr(int'($urandom_range(0, 4)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle variant of the RISC-V core. It sequences one shared ALU, one unified memory port and the register file over several cycles per instruction. It drives the 2-bit `aluOp` consumed by the ALU control decoder, plus mux selects and write strobes, and handshakes with memory through `mem_ready`. It also counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: instruction bits [6:0] from the instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `aluOp` output 2: 00 = add (address/PC), 01 = subtract (branch compare), 10 = R-type (decode by funct).
- `alu_src_a` output 1: 0 = PC, 1 = rs1.
- `alu_src_b` output 2: 00 = rs2, 01 = constant 4, 10 = immediate. 11 is unused.
- `iord` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` output 1 each: memory request strobes.
- `ir_write`, `pc_write` output 1 each: instruction-register load and unconditional PC load.
- `pc_write_cond` output 1: PC load qualified externally by the ALU zero flag.
- `pc_src` output 1: 0 = ALU result, 1 = ALUOut.
- `reg_write`, `mem_to_reg` output 1 each: register-file write enable and write-data select (1 = memory data).
- `retire` output 1: one-cycle pulse when an instruction completes.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `retired_cnt` output CNT_W: count of retired instructions.
- `state` output 4: current state, for debug.

## Operation
- Supported opcodes:
  - LOAD 0000011
  - STORE 0100011
  - RTYPE 0110011
  - BRANCH 1100011
- State encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, LOAD_WB 4
  - MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8
  - Encodings 9 to 15 go to FETCH on the next clock.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluOp`=00.
  - If `mem_ready`=1: `ir_write`=1 and `pc_write`=1 in the same cycle, then go to DECODE.
  - Otherwise hold in FETCH; `ir_write` and `pc_write` stay 0.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=10, `aluOp`=00 (computes the branch target into ALUOut).
  - `opcode` is latched into an internal register.
  - Next state: LOAD or STORE go to MEM_ADDR, RTYPE to EXEC_R, BRANCH to BRANCH.
  - Any other opcode: `illegal`=1 and go to FETCH. No retire, and the counter is unchanged.
- MEM_ADDR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `aluOp`=00.
  - Next state from the latched opcode: LOAD to MEM_RD, STORE to MEM_WR.
- MEM_RD:
  - Outputs: `mem_read`=1, `iord`=1.
  - Wait for `mem_ready`, then go to LOAD_WB.
- LOAD_WB:
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `retire`=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: `mem_write`=1, `iord`=1.
  - When `mem_ready`=1: `retire`=1 and go to FETCH.
- EXEC_R:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `aluOp`=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: `reg_write`=1, `mem_to_reg`=0, `retire`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `aluOp`=01, `pc_write_cond`=1, `pc_src`=1, `retire`=1.
  - Next state: FETCH. A branch retires whether it is taken or not.
- `retired_cnt`:
  - Increments by 1 on each clock edge where `retire`=1.
  - Wraps from all-ones to 0 with no flag.
- Output decode:
  - All outputs are combinational decodes of `state`, with `mem_ready` qualifying the pulses in wait states.
  - Registered elements: `state`, the latched opcode, and `retired_cnt`.

## Timing
- Reset (`rst_n`=0), applied at any time including mid-access:
  - Immediately: `state`=FETCH, `retired_cnt`=0, latched opcode=0.
  - All other outputs are forced to 0 while `rst_n`=0, including FETCH's `mem_read` and `aluOp`=00.
  - First FETCH request is issued in the first cycle after `rst_n` deasserts.
- Cycles per instruction with `mem_ready` held at 1:
  - BRANCH 3
  - RTYPE 4
  - STORE 4
  - LOAD 5
  - Illegal opcode: 2 (FETCH, DECODE).
- Each cycle that `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
  - The request strobe and `iord` are held stable throughout the wait.
- `mem_ready` is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- `opcode` is sampled only in DECODE. Changes in any other state have no effect.
- `retire` and the counter increment:
  - `retired_cnt` shows the new value the cycle after the `retire` pulse.
  - `retire` fires at most once per instruction and never on an illegal opcode.

## Test plan
- Reset, then RTYPE with `mem_ready`=1:
  - `state` sequence 0,1,6,7,0.
  - `aluOp`=10 in EXEC_R; `reg_write`=1 in R_WB.
  - `retired_cnt`=1 after 4 cycles.
- LOAD with `mem_ready` low for 3 cycles in MEM_RD:
  - `state` sequence 0,1,2,3,3,3,3,4,0 (8 cycles).
  - `mem_read`=1 and `iord`=1 held throughout the wait; `mem_to_reg`=1 in LOAD_WB.
- STORE then BRANCH, with `mem_ready`=1:
  - STORE: `mem_write`=1 for exactly one cycle.
  - BRANCH: `aluOp`=01 and `pc_write_cond`=1 for one cycle.
  - `retired_cnt`=2 after 7 cycles.
- FETCH with `mem_ready`=0 for 2 cycles, then opcode 1111111:
  - `ir_write`/`pc_write` pulse only on the ready cycle.
  - `illegal` pulses in DECODE, then return to FETCH.
  - `retired_cnt` unchanged.
- Assert `rst_n`=0 mid-MEM_RD:
  - `state`=0, `retired_cnt`=0 and `mem_read`=0 with no clock edge.
  - After release, FETCH proceeds normally.
- `CNT_W`=4, run 17 R-type instructions:
  - `retired_cnt` wraps 15→0→1.
  - No other output is disturbed.
